// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the instruction memory it fills.
// Holds the state encoding, bus widths, default depth and the WordCount range check.
package instruction_loader_pkg;

   localparam int unsigned DEFAULT_DEPTH       = 32;
   localparam int unsigned DEFAULT_COUNT_WIDTH = 6;
   localparam int unsigned BYTE_W              = 8;
   localparam int unsigned WORD_W              = 32;
   localparam int unsigned BYTES_PER_WORD      = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } loader_state_e;

   // A session must load at least one word and must fit in the memory.
   function automatic logic count_ok(input int unsigned count, input int unsigned depth);
      return (count != 0) && (count <= depth);
   endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Control, byte-stream and memory-write signals of the instruction loader.
// The master drives the session and the byte stream; the slave is the loader.
interface instruction_loader_if
   import instruction_loader_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
);

   logic                   start;
   logic [COUNT_WIDTH-1:0] word_count;
   logic [BYTE_W-1:0]      byte_in;
   logic                   byte_valid;
   logic                   byte_ready;
   logic                   write_enable;
   logic [WORD_W-1:0]      write_address;
   logic [WORD_W-1:0]      write_data;
   logic                   busy;
   logic                   done;
   logic                   error;
   logic [BYTE_W-1:0]      checksum;

   modport master (
      output start, word_count, byte_in, byte_valid,
      input  byte_ready, write_enable, write_address, write_data,
             busy, done, error, checksum
   );

   modport slave (
      input  start, word_count, byte_in, byte_valid,
      output byte_ready, write_enable, write_address, write_data,
             busy, done, error, checksum
   );

endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word.
// word_c is the word including the byte being loaded; full_c marks the 4th byte.
module instruction_loader_byte_assembler
   import instruction_loader_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              load,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word_c,
   output logic              full_c
);

   localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

   logic [IDX_W-1:0]  idx_q;
   logic [WORD_W-1:0] word_q;

   // Insert the incoming byte at the current lane.
   always_comb begin
      word_c = word_q;
      word_c[{idx_q, 3'b000} +: BYTE_W] = byte_in;
   end

   assign full_c = load && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else if (clear) begin
         idx_q  <= '0;
         word_q <= '0;
      end else if (load) begin
         idx_q  <= idx_q + IDX_W'(1);
         word_q <= word_c;
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte stream into instruction memory as little-endian 32-bit words.
// Holds the session FSM, word address counter and running byte checksum.
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int unsigned DEPTH       = DEFAULT_DEPTH,
   parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
)
(
   input logic                 clock,
   input logic                 reset_n,
   instruction_loader_if.slave bus
);

   loader_state_e          state_q;
   loader_state_e          state_d;

   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] addr_q;
   logic [BYTE_W-1:0]      checksum_q;
   logic [WORD_W-1:0]      wr_data_q;
   logic                   ready_q;
   logic                   we_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   error_q;

   logic                   take_c;
   logic                   start_ok_c;
   logic                   start_bad_c;
   logic                   last_word_c;
   logic [WORD_W-1:0]      word_c;
   logic                   full_c;

   // A byte moves only while collecting; byte_ready tracks ST_COLLECT exactly.
   assign take_c = (state_q == ST_COLLECT) && bus.byte_valid;

   instruction_loader_byte_assembler u_byte_assembler (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (start_ok_c),
      .load    (take_c),
      .byte_in (bus.byte_in),
      .word_c  (word_c),
      .full_c  (full_c)
   );

   // Next-state and session control decode.
   always_comb begin
      state_d     = state_q;
      start_ok_c  = 1'b0;
      start_bad_c = 1'b0;
      last_word_c = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               if (count_ok(32'(bus.word_count), DEPTH)) begin
                  start_ok_c = 1'b1;
                  state_d    = ST_COLLECT;
               end else begin
                  start_bad_c = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_COLLECT: begin
            if (full_c) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            last_word_c = ((addr_q + COUNT_WIDTH'(1)) == count_q);
            state_d     = last_word_c ? ST_DONE : ST_COLLECT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         addr_q     <= '0;
         checksum_q <= '0;
         wr_data_q  <= '0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         // Status strobes are registered from the next state so they align with it.
         ready_q <= (state_d == ST_COLLECT);
         we_q    <= (state_d == ST_WRITE);
         busy_q  <= (state_d == ST_COLLECT) || (state_d == ST_WRITE);

         if (start_ok_c) begin
            count_q    <= bus.word_count;
            addr_q     <= '0;
            checksum_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
         end

         if (start_bad_c) begin
            done_q  <= 1'b0;
            error_q <= 1'b1;
         end

         if (take_c) begin
            checksum_q <= checksum_q + bus.byte_in;
            if (full_c) begin
               wr_data_q <= word_c;
            end
         end

         if (state_q == ST_WRITE) begin
            addr_q <= addr_q + COUNT_WIDTH'(1);
            if (last_word_c) begin
               done_q <= 1'b1;
            end
         end
      end
   end

   assign bus.byte_ready    = ready_q;
   assign bus.write_enable  = we_q;
   assign bus.write_address = WORD_W'(addr_q);
   assign bus.write_data    = wr_data_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.error         = error_q;
   assign bus.checksum      = checksum_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader: byte streams with gaps checked against
// a queue-based model of the expected memory writes, checksum and status flags.
module tb_instruction_loader;
   import instruction_loader_pkg::*;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned CW    = 6;

   typedef logic [7:0] byte_t;

   logic clock;
   logic reset_n;

   instruction_loader_if #(.COUNT_WIDTH(CW)) bus ();

   instruction_loader #(.DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   logic        we_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Record every write and check the per-cycle rules that hold during a write.
   always @(negedge clock) begin
      if (bus.write_enable === 1'b1) begin
         obs_addr.push_back(bus.write_address);
         obs_data.push_back(bus.write_data);
         check("we_single_cycle", 32'(we_prev), 32'd0);
         check("we_addr_in_range", 32'(bus.write_address < DEPTH), 32'd1);
         check("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
      end
      we_prev = bus.write_enable;
   end

   task automatic check_all_zero(input string tag);
      logic [31:0] flags;
      flags = {24'd0, bus.byte_ready, bus.write_enable, bus.busy, bus.done, bus.error, 3'd0};
      check({tag, "_flags"}, flags, 32'd0);
      check({tag, "_addr"}, bus.write_address, 32'd0);
      check({tag, "_data"}, bus.write_data, 32'd0);
      check({tag, "_cksum"}, 32'(bus.checksum), 32'd0);
   endtask

   task automatic do_start(input int wc);
      @(negedge clock);
      bus.word_count = CW'(wc);
      bus.start      = 1'b1;
      @(negedge clock);
      bus.start      = 1'b0;
   endtask

   task automatic make_bytes(input int n, output byte_t q[$]);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(byte_t'($urandom_range(255)));
   endtask

   // Offer bytes with random idle gaps; optionally pulse Start mid-stream.
   task automatic send_bytes(input byte_t q[$], input int gap_pct, input int mid_start_at);
      int i      = 0;
      int budget = 0;
      bit fired  = 1'b0;
      while (i < q.size()) begin
         @(negedge clock);
         bus.start      = 1'b0;
         bus.byte_valid = 1'b0;
         bus.byte_in    = byte_t'($urandom_range(255));
         budget++;
         if (budget > 20000) begin
            check("send_timeout", 32'(i), 32'(q.size()));
            return;
         end
         if (!fired && mid_start_at >= 0 && i == mid_start_at) begin
            fired          = 1'b1;
            check("busy_at_mid_start", 32'(bus.busy), 32'd1);
            bus.word_count = CW'(1);
            bus.start      = 1'b1;
         end
         if ($urandom_range(99) < gap_pct) continue;
         bus.byte_in    = q[i];
         bus.byte_valid = 1'b1;
         if (bus.byte_ready) i++;
      end
      @(negedge clock);
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
   endtask

   // Full session: model writes as little-endian words at consecutive addresses.
   task automatic run_session(input int wc, input byte_t q[$], input int gap_pct,
                              input int mid_start_at);
      int          base;
      int          t;
      int          sum;
      logic [31:0] exp_word;
      base = obs_addr.size();
      do_start(wc);
      check("busy_after_start", 32'(bus.busy), 32'd1);
      check("ready_after_start", 32'(bus.byte_ready), 32'd1);
      check("done_cleared", 32'(bus.done), 32'd0);
      check("error_cleared", 32'(bus.error), 32'd0);
      check("cksum_cleared", 32'(bus.checksum), 32'd0);
      check("addr_cleared", bus.write_address, 32'd0);
      send_bytes(q, gap_pct, mid_start_at);
      t = 0;
      while (bus.done !== 1'b1 && t < 100) begin
         @(negedge clock);
         t++;
      end
      check("done_set", 32'(bus.done), 32'd1);
      check("busy_clear", 32'(bus.busy), 32'd0);
      check("ready_done", 32'(bus.byte_ready), 32'd0);
      check("addr_done", bus.write_address, 32'(wc));
      sum = 0;
      foreach (q[k]) sum += int'(q[k]);
      check("checksum", 32'(bus.checksum), 32'(sum % 256));
      check("num_writes", 32'(obs_addr.size() - base), 32'(wc));
      for (int w = 0; w < wc && base + w < obs_addr.size(); w++) begin
         exp_word = 0;
         for (int b = 0; b < 4; b++) exp_word += 32'(q[4*w + b]) << (8 * b);
         check("write_addr", obs_addr[base + w], 32'(w));
         check("write_data", obs_data[base + w], exp_word);
      end
   endtask

   task automatic bad_start(input int wc);
      int base;
      base = obs_addr.size();
      do_start(wc);
      check("bad_error", 32'(bus.error), 32'd1);
      check("bad_done", 32'(bus.done), 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         bus.byte_valid = 1'b1;
         bus.byte_in    = byte_t'($urandom_range(255));
         check("bad_ready", 32'(bus.byte_ready), 32'd0);
         check("bad_busy", 32'(bus.busy), 32'd0);
      end
      @(negedge clock);
      bus.byte_valid = 1'b0;
      check("bad_no_write", 32'(obs_addr.size() - base), 32'd0);
   endtask

   initial begin
      byte_t q[$];
      int    base;
      bus.start      = 1'b0;
      bus.word_count = '0;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;
      reset_n        = 1'b0;

      #12;
      check_all_zero("reset");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("idle_after_reset_busy", 32'(bus.busy), 32'd0);

      // Directed single word.
      q = '{8'h13, 8'h00, 8'h50, 8'h00};
      run_session(1, q, 0, -1);
      check("directed_data", bus.write_data, 32'h0050_0013);
      check("directed_cksum", 32'(bus.checksum), 32'h63);

      // Illegal counts, the first issued from DONE.
      bad_start(0);
      bad_start(33);

      // Fill the whole memory with gaps.
      make_bytes(4 * 32, q);
      run_session(32, q, 30, -1);

      // Start pulse during collection must be ignored.
      make_bytes(4 * 5, q);
      run_session(5, q, 50, 6);

      // Restart from DONE with new data.
      make_bytes(4 * 3, q);
      run_session(3, q, 20, -1);

      // Reset after two bytes of the third word.
      base = obs_addr.size();
      do_start(4);
      make_bytes(10, q);
      send_bytes(q, 25, -1);
      repeat (2) @(negedge clock);
      check("pre_reset_writes", 32'(obs_addr.size() - base), 32'd2);
      #2 reset_n = 1'b0;
      #1 check_all_zero("midreset");
      repeat (3) @(negedge clock);
      check("midreset_no_write", 32'(obs_addr.size() - base), 32'd2);
      reset_n = 1'b1;
      @(negedge clock);
      make_bytes(8, q);
      run_session(2, q, 25, -1);

      // Random sessions.
      for (int s = 0; s < 4; s++) begin
         int wc;
         wc = int'($urandom_range(1, 8));
         make_bytes(4 * wc, q);
         run_session(wc, q, int'($urandom_range(0, 60)), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 32-bit words in the target instruction memory.
REQ-002 SHALL have parameter COUNT_WIDTH, default 6, width of WordCount; it SHALL be able to hold DEPTH.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Start, input, 1, a one-cycle request to begin a load session.
REQ-006 SHALL have port WordCount, input, COUNT_WIDTH, number of words to load; sampled only when Start is accepted.
REQ-007 SHALL have port ByteIn, input, 8, one program byte.
REQ-008 SHALL have port ByteValid, input, 1, meaning ByteIn is valid.
REQ-009 SHALL have port ByteReady, output, 1, meaning the loader accepts ByteIn this cycle.
REQ-010 SHALL have port WriteEnable, output, 1, the instruction-memory write strobe.
REQ-011 SHALL have port WriteAddress, output, 32, the word index to write; it is a word index, not a byte address, matching the memory indexing.
REQ-012 SHALL have port WriteData, output, 32, the assembled instruction word.
REQ-013 SHALL have port Busy, output, 1, high while in the COLLECT or WRITE state.
REQ-014 SHALL have port Done, output, 1, sticky; high after a successful session completes.
REQ-015 SHALL have port Error, output, 1, sticky; high after Start with an invalid WordCount.
REQ-016 SHALL have port Checksum, output, 8, the modulo-256 sum of all bytes accepted in the current session.

Function
REQ-017 SHALL implement the states IDLE, COLLECT, WRITE and DONE.
REQ-018 Start SHALL be accepted only in IDLE or DONE; Start in COLLECT or WRITE SHALL be ignored.
REQ-019 On an accepted Start with 1 <= WordCount <= DEPTH: go to COLLECT; clear the address, byte index, Checksum, Done and Error; latch WordCount.
REQ-020 On an accepted Start with WordCount = 0 or WordCount > DEPTH: set Error, clear Done, go to IDLE, and issue no write.
REQ-021 ByteReady SHALL be 1 only in COLLECT; a byte is transferred on a cycle where ByteValid and ByteReady are both 1.
REQ-022 Bytes SHALL be assembled little-endian: the 1st accepted byte goes to WriteData[7:0], and the 4th to [31:24].
REQ-023 Checksum SHALL add each accepted byte, wrapping modulo 256, and update at the same edge as the transfer.
REQ-024 The edge that accepts the 4th byte SHALL enter WRITE; in WRITE, WriteEnable is 1 for exactly one cycle, with WriteAddress and WriteData stable.
REQ-025 ByteReady SHALL be 0 in WRITE, so there is no back-to-back acceptance across a word boundary.
REQ-026 On leaving WRITE, WriteAddress SHALL increment by 1; if the number of words written equals the latched WordCount, go to DONE and set Done, otherwise go to COLLECT.
REQ-027 WriteAddress SHALL never exceed DEPTH-1 while WriteEnable is 1; no wrap-around is possible, by REQ-020.
REQ-028 Gaps in ByteValid SHALL stall collection indefinitely, with no timeout.
REQ-029 DONE SHALL hold WriteAddress = WordCount and keep Checksum until the next accepted Start.
REQ-030 WriteEnable SHALL be 0 in every state other than WRITE.

Reset
REQ-031 On Reset_n low, the block SHALL go to IDLE immediately, without waiting for a clock edge.
REQ-032 Reset SHALL clear every output to 0: ByteReady, WriteEnable, WriteAddress, WriteData, Busy, Done, Error and Checksum.
REQ-033 Reset mid-session SHALL discard the partial word and issue no write; a WRITE cycle cut short by reset SHALL drop WriteEnable immediately.
REQ-034 After Reset_n rises, the block SHALL remain in IDLE until Start is accepted.

Structure
REQ-035 The state encoding and the DEPTH default SHALL be placed in a shared package used by the memory and the loader.
REQ-036 One sub-module is natural: byte_assembler, which holds the byte index and the 32-bit shift/insert register and asserts a word-full flag.
REQ-037 The FSM, address counter and checksum SHALL reside in instruction_loader.

Verification
REQ-038 Start with WordCount=1, then bytes 13,00,50,00 -> one WriteEnable pulse with WriteAddress=0, WriteData=0x00500013, Done=1, Checksum=0x63.
REQ-039 Start with WordCount=32 and 128 bytes -> 32 writes to addresses 0..31, each exactly one cycle; no write to address 32; Done=1.
REQ-040 Start with WordCount=0, and separately WordCount=33 -> Error=1, Done=0, ByteReady stays 0, and no WriteEnable.
REQ-041 Random ByteValid gaps plus a Start pulse issued during COLLECT -> words are unchanged and the Start is ignored, with the latched count retained.
REQ-042 Reset_n pulled low after 2 bytes of word 3 -> all outputs 0 at once and no write; a subsequent Start with WordCount=2 writes addresses 0 and 1.
REQ-043 Start in DONE with new data -> Done clears, Checksum restarts from 0, and addresses restart at 0.
